// File: rtl/cdc_fifo_src_arbiter_if.sv
// cdc_fifo_src_arbiter_if: requester, FIFO source and flush handshake signals of the arbiter
interface cdc_fifo_src_arbiter_if #(
  parameter int  NumIn = 4,
  parameter type T     = logic
);
  localparam int IdxWidth = $clog2(NumIn);
  T                    in_data_i [NumIn];
  logic [NumIn-1:0]    in_last_i;
  logic [NumIn-1:0]    in_valid_i;
  logic [NumIn-1:0]    in_ready_o;
  T                    fifo_data_o;
  logic [IdxWidth-1:0] fifo_idx_o;
  logic                fifo_last_o;
  logic                fifo_valid_o;
  logic                fifo_ready_i;
  logic                fifo_clr_o;
  logic                flush_req_i;
  logic                flush_ack_o;
  logic                busy_o;
  modport master (
    input  in_data_i, in_last_i, in_valid_i, fifo_ready_i, flush_req_i,
    output in_ready_o, fifo_data_o, fifo_idx_o, fifo_last_o, fifo_valid_o,
           fifo_clr_o, flush_ack_o, busy_o
  );
  modport slave (
    output in_data_i, in_last_i, in_valid_i, fifo_ready_i, flush_req_i,
    input  in_ready_o, fifo_data_o, fifo_idx_o, fifo_last_o, fifo_valid_o,
           fifo_clr_o, flush_ack_o, busy_o
  );
endinterface

// File: rtl/cdc_fifo_src_arbiter.sv
// cdc_fifo_src_arbiter: packet round-robin sharing of a CDC FIFO source port with flush sequencing
module cdc_fifo_src_arbiter #(
  parameter  int  NumIn    = 4,
  parameter  type T        = logic,
  localparam int  IdxWidth = $clog2(NumIn)
) (
  input logic clk_i,
  input logic rst_ni,
  cdc_fifo_src_arbiter_if.master bus
);
  typedef enum logic [1:0] {ARB, LOCK, CLEAR, ACK} state_t;
  state_t              state_q;
  logic [IdxWidth-1:0] rr_ptr_q, sel_q, pick, act;
  logic                pick_ok, act_ok, hs;

  function automatic logic [IdxWidth-1:0] wrap_inc(input logic [IdxWidth-1:0] x);
    return (int'(x) == NumIn - 1) ? '0 : x + 1'b1;
  endfunction

  // Round-robin search from rr_ptr_q; descending scan so the nearest valid requester wins
  always_comb begin
    int j;
    j       = 0;
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = NumIn - 1; k >= 0; k--) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NumIn) j -= NumIn;
      if (bus.in_valid_i[IdxWidth'(j)]) begin
        pick    = IdxWidth'(j);
        pick_ok = 1'b1;
      end
    end
    if (bus.flush_req_i) pick_ok = 1'b0;
  end

  // Zero-latency steering of the active requester onto the FIFO source port
  always_comb begin
    act              = (state_q == LOCK) ? sel_q : pick;
    act_ok           = (state_q == LOCK) || (state_q == ARB && pick_ok);
    bus.fifo_valid_o = act_ok && bus.in_valid_i[act];
    bus.fifo_data_o  = act_ok ? bus.in_data_i[act] : '0;
    bus.fifo_last_o  = act_ok && bus.in_last_i[act];
    bus.fifo_idx_o   = act_ok ? act : '0;
    hs               = bus.fifo_valid_o && bus.fifo_ready_i;
    bus.in_ready_o   = '0;
    if (hs) bus.in_ready_o[act] = 1'b1;
    bus.fifo_clr_o   = (state_q == CLEAR);
    bus.flush_ack_o  = (state_q == ACK);
    bus.busy_o       = (state_q != ARB);
  end

  // Grant locking, pointer advance on packet end, and the flush clear/ack sequence
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ARB;
      rr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      case (state_q)
        ARB:
          if (bus.flush_req_i) state_q <= CLEAR;
          else if (pick_ok) begin
            if (hs && bus.fifo_last_o) rr_ptr_q <= wrap_inc(pick);
            else begin
              state_q <= LOCK;
              sel_q   <= pick;
            end
          end
        LOCK:
          if (hs && bus.fifo_last_o) begin
            rr_ptr_q <= wrap_inc(sel_q);
            state_q  <= bus.flush_req_i ? CLEAR : ARB;
          end
        CLEAR: state_q <= ACK;
        default: if (!bus.flush_req_i) state_q <= ARB;
      endcase
    end
  end
endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// tb_cdc_fifo_src_arbiter: directed vectors for packet round-robin, backpressure, flush and reset
module tb_cdc_fifo_src_arbiter;
  typedef logic [7:0] byte_t;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  cdc_fifo_src_arbiter_if #(.NumIn(4), .T(byte_t)) b4 ();
  cdc_fifo_src_arbiter_if #(.NumIn(3), .T(byte_t)) b3 ();

  cdc_fifo_src_arbiter #(.NumIn(4), .T(byte_t)) u4 (.clk_i(clk), .rst_ni(rst_n), .bus(b4.master));
  cdc_fifo_src_arbiter #(.NumIn(3), .T(byte_t)) u3 (.clk_i(clk), .rst_ni(rst_n), .bus(b3.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic req4(input int i, input logic v, input logic l, input byte_t d);
    b4.in_valid_i[i] = v;
    b4.in_last_i[i]  = l;
    b4.in_data_i[i]  = d;
  endtask

  task automatic req3(input int i, input logic v, input logic l, input byte_t d);
    b3.in_valid_i[i] = v;
    b3.in_last_i[i]  = l;
    b3.in_data_i[i]  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) req4(i, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) req3(i, 1'b0, 1'b0, 8'h00);
    b4.fifo_ready_i = 1'b0;
    b4.flush_req_i  = 1'b0;
    b3.fifo_ready_i = 1'b0;
    b3.flush_req_i  = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_busy", b4.busy_o, 0);
    chk("rst_clr", b4.fifo_clr_o, 0);
    chk("rst_ack", b4.flush_ack_o, 0);
    chk("rst_valid", b4.fifo_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // single-beat packets from all four requesters
    for (int i = 0; i < 4; i++) req4(i, 1'b1, 1'b1, byte_t'(8'h10 + i));
    b4.fifo_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_idx", b4.fifo_idx_o, k % 4);
      chk("rr_data", b4.fifo_data_o, 8'h10 + k % 4);
      chk("rr_ready", b4.in_ready_o, 1 << (k % 4));
      @(negedge clk);
    end
    for (int i = 1; i < 4; i++) req4(i, 1'b0, 1'b0, 8'h00);
    #1;
    chk("wrap_idx", b4.fifo_idx_o, 0);
    // three-beat packet from req 1 holds off req 2
    @(negedge clk);
    req4(0, 1'b0, 1'b0, 8'h00);
    req4(1, 1'b1, 1'b0, 8'hA1);
    req4(2, 1'b1, 1'b1, 8'hB2);
    #1;
    chk("pkt_b1_idx", b4.fifo_idx_o, 1);
    chk("pkt_b1_last", b4.fifo_last_o, 0);
    chk("pkt_b1_ready", b4.in_ready_o, 4'b0010);
    @(negedge clk);
    req4(1, 1'b1, 1'b0, 8'hA2);
    #1;
    chk("pkt_b2_idx", b4.fifo_idx_o, 1);
    chk("pkt_b2_data", b4.fifo_data_o, 8'hA2);
    chk("pkt_b2_ready", b4.in_ready_o, 4'b0010);
    chk("pkt_b2_busy", b4.busy_o, 1);
    @(negedge clk);
    req4(1, 1'b1, 1'b1, 8'hA3);
    #1;
    chk("pkt_b3_idx", b4.fifo_idx_o, 1);
    chk("pkt_b3_last", b4.fifo_last_o, 1);
    @(negedge clk);
    req4(1, 1'b0, 1'b0, 8'h00);
    #1;
    chk("pkt_next_idx", b4.fifo_idx_o, 2);
    chk("pkt_next_data", b4.fifo_data_o, 8'hB2);
    chk("pkt_next_busy", b4.busy_o, 0);
    @(negedge clk);
    req4(2, 1'b0, 1'b0, 8'h00);
    #1;
    chk("idle_valid", b4.fifo_valid_o, 0);
    chk("idle_idx", b4.fifo_idx_o, 0);
    chk("idle_data", b4.fifo_data_o, 0);
    // backpressure on req 3 while req 0 arrives
    b4.fifo_ready_i = 1'b0;
    req4(3, 1'b1, 1'b1, 8'h33);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) req4(0, 1'b1, 1'b1, 8'h44);
      #1;
      chk("bp_idx", b4.fifo_idx_o, 3);
      chk("bp_data", b4.fifo_data_o, 8'h33);
      chk("bp_valid", b4.fifo_valid_o, 1);
      chk("bp_ready", b4.in_ready_o, 0);
    end
    @(negedge clk);
    b4.fifo_ready_i = 1'b1;
    #1;
    chk("bp_rel_idx", b4.fifo_idx_o, 3);
    chk("bp_rel_ready", b4.in_ready_o, 4'b1000);
    @(negedge clk);
    req4(3, 1'b0, 1'b0, 8'h00);
    #1;
    chk("bp_after_idx", b4.fifo_idx_o, 0);
    chk("bp_after_data", b4.fifo_data_o, 8'h44);
    @(negedge clk);
    req4(0, 1'b0, 1'b0, 8'h00);
    // flush raised in beat 2 of a 4-beat packet from req 1
    @(negedge clk);
    req4(1, 1'b1, 1'b0, 8'hC1);
    req4(2, 1'b1, 1'b1, 8'hD2);
    #1;
    chk("fl_b1_idx", b4.fifo_idx_o, 1);
    @(negedge clk);
    req4(1, 1'b1, 1'b0, 8'hC2);
    b4.flush_req_i = 1'b1;
    #1;
    chk("fl_b2_idx", b4.fifo_idx_o, 1);
    chk("fl_b2_valid", b4.fifo_valid_o, 1);
    chk("fl_b2_clr", b4.fifo_clr_o, 0);
    @(negedge clk);
    req4(1, 1'b1, 1'b0, 8'hC3);
    #1;
    chk("fl_b3_data", b4.fifo_data_o, 8'hC3);
    chk("fl_b3_valid", b4.fifo_valid_o, 1);
    @(negedge clk);
    req4(1, 1'b1, 1'b1, 8'hC4);
    #1;
    chk("fl_b4_idx", b4.fifo_idx_o, 1);
    chk("fl_b4_last", b4.fifo_last_o, 1);
    @(negedge clk);
    req4(1, 1'b0, 1'b0, 8'h00);
    #1;
    chk("fl_clear_clr", b4.fifo_clr_o, 1);
    chk("fl_clear_valid", b4.fifo_valid_o, 0);
    chk("fl_clear_ready", b4.in_ready_o, 0);
    @(negedge clk);
    #1;
    chk("fl_ack_clr", b4.fifo_clr_o, 0);
    chk("fl_ack_ack", b4.flush_ack_o, 1);
    chk("fl_ack_valid", b4.fifo_valid_o, 0);
    @(negedge clk);
    b4.flush_req_i = 1'b0;
    #1;
    chk("fl_hold_ack", b4.flush_ack_o, 1);
    chk("fl_hold_valid", b4.fifo_valid_o, 0);
    @(negedge clk);
    #1;
    chk("fl_done_ack", b4.flush_ack_o, 0);
    chk("fl_done_busy", b4.busy_o, 0);
    chk("fl_done_idx", b4.fifo_idx_o, 2);
    chk("fl_done_data", b4.fifo_data_o, 8'hD2);
    @(negedge clk);
    req4(2, 1'b0, 1'b0, 8'h00);
    // asynchronous reset while req 2 is locked
    @(negedge clk);
    b4.fifo_ready_i = 1'b0;
    req4(2, 1'b1, 1'b1, 8'hE2);
    #1;
    chk("rl_idx", b4.fifo_idx_o, 2);
    @(negedge clk);
    req4(0, 1'b1, 1'b1, 8'hE0);
    #1;
    chk("rl_lock_idx", b4.fifo_idx_o, 2);
    chk("rl_lock_busy", b4.busy_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rl_rst_busy", b4.busy_o, 0);
    chk("rl_rst_idx", b4.fifo_idx_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    b4.fifo_ready_i = 1'b1;
    #1;
    chk("rl_rel_idx", b4.fifo_idx_o, 0);
    chk("rl_rel_data", b4.fifo_data_o, 8'hE0);
    chk("rl_rel_clr", b4.fifo_clr_o, 0);
    chk("rl_rel_busy", b4.busy_o, 0);
    @(negedge clk);
    req4(0, 1'b0, 1'b0, 8'h00);
    #1;
    chk("rl_next_idx", b4.fifo_idx_o, 2);
    @(negedge clk);
    req4(2, 1'b0, 1'b0, 8'h00);
    // three requesters: pointer wraps from 2 to 0
    b3.fifo_ready_i = 1'b1;
    req3(2, 1'b1, 1'b1, 8'h62);
    #1;
    chk("n3_first_idx", b3.fifo_idx_o, 2);
    @(negedge clk);
    req3(0, 1'b1, 1'b1, 8'h60);
    req3(1, 1'b1, 1'b1, 8'h61);
    #1;
    chk("n3_wrap_idx", b3.fifo_idx_o, 0);
    chk("n3_wrap_data", b3.fifo_data_o, 8'h60);
    @(negedge clk);
    #1;
    chk("n3_seq1", b3.fifo_idx_o, 1);
    @(negedge clk);
    #1;
    chk("n3_seq2", b3.fifo_idx_o, 2);
    @(negedge clk);
    #1;
    chk("n3_seq0", b3.fifo_idx_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
